// File: rtl/nice_gemm_ctrl.sv
// NICE custom-instruction front end for a GEMM engine. It decodes config and start
// instructions, holds the GEMM configuration, launches and times the engine, and returns a response.
module nice_gemm_ctrl #(
  parameter logic [6:0]  CUSTOM_OPCODE = 7'b0101011,
  parameter logic [31:0] TIMEOUT_CYC   = 32'd65535
) (
  input  logic        nice_clk,
  input  logic        nice_rst_n,
  input  logic        nice_req_valid,
  output logic        nice_req_ready,
  input  logic [31:0] nice_req_instr,
  input  logic [31:0] nice_req_rs1,
  input  logic [31:0] nice_req_rs2,
  output logic        nice_rsp_multicyc_valid,
  input  logic        nice_rsp_multicyc_ready,
  output logic [31:0] nice_rsp_multicyc_dat,
  output logic        nice_rsp_multicyc_err,
  output logic        nice_mem_holdup,
  output logic        eng_start,
  output logic        eng_abort,
  input  logic        eng_done,
  input  logic        eng_err,
  output logic [31:0] cfg_a_base,
  output logic [31:0] cfg_b_base,
  output logic [31:0] cfg_c_base,
  output logic [31:0] cfg_stride_a,
  output logic [31:0] cfg_stride_b,
  output logic [31:0] cfg_stride_c,
  output logic [15:0] cfg_m,
  output logic [15:0] cfg_n,
  output logic [15:0] cfg_k,
  output logic [7:0]  cfg_flags,
  output logic [31:0] cfg_scale,
  output logic [31:0] cfg_zp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  logic [1:0]  state;
  logic [31:0] counter;
  logic [31:0] cnt_inc;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_cfg;
  logic       is_start;
  logic       dims_zero;
  logic       accept;
  logic       timeout_hit;
  logic       unused_ok;

  assign opcode = nice_req_instr[6:0];
  assign funct3 = nice_req_instr[14:12];
  assign funct7 = nice_req_instr[31:25];
  assign unused_ok = &{1'b0, nice_req_instr[24:15], nice_req_instr[11:7]};

  assign is_cfg   = (opcode == CUSTOM_OPCODE) && (funct3 == 3'b011) &&
                    !funct7[6] && $onehot(funct7[5:0]);
  assign is_start = (opcode == CUSTOM_OPCODE) && (funct3 == 3'b010) &&
                    (funct7 == 7'b1000000);
  assign dims_zero = (cfg_m == 16'd0) || (cfg_n == 16'd0) || (cfg_k == 16'd0);

  // ready is also gated by reset so every output reads 0 while reset is held
  assign nice_req_ready = (state == S_IDLE) && nice_rst_n;
  assign accept         = nice_req_valid && nice_req_ready;

  // counter holds cycles already spent in RUN; cnt_inc is the count including this cycle
  assign cnt_inc     = counter + 32'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_CYC);

  assign eng_start               = (state == S_START);
  assign eng_abort               = (state == S_RUN) && !eng_done && timeout_hit;
  assign nice_mem_holdup         = (state == S_START) || (state == S_RUN);
  assign nice_rsp_multicyc_valid = (state == S_RSP);
  assign nice_rsp_multicyc_dat   = rsp_dat;
  assign nice_rsp_multicyc_err   = rsp_err;

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      state   <= S_IDLE;
      counter <= 32'd0;
      rsp_dat <= 32'd0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_dat <= 32'd0;
            if (is_cfg) begin
              rsp_err <= 1'b0;
              state   <= S_RSP;
            end else if (is_start && !dims_zero) begin
              state <= S_START;
            end else begin
              rsp_err <= 1'b1;
              state   <= S_RSP;
            end
          end
        end
        S_START: begin
          counter <= 32'd0;
          state   <= S_RUN;
        end
        S_RUN: begin
          counter <= cnt_inc;
          if (eng_done) begin
            rsp_dat <= cnt_inc;
            rsp_err <= eng_err;
            state   <= S_RSP;
          end else if (timeout_hit) begin
            rsp_dat <= cnt_inc;
            rsp_err <= 1'b1;
            state   <= S_RSP;
          end
        end
        default: begin
          if (nice_rsp_multicyc_ready) begin
            rsp_dat <= 32'd0;
            rsp_err <= 1'b0;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      cfg_a_base   <= 32'd0;
      cfg_b_base   <= 32'd0;
      cfg_c_base   <= 32'd0;
      cfg_stride_a <= 32'd0;
      cfg_stride_b <= 32'd0;
      cfg_stride_c <= 32'd0;
      cfg_m        <= 16'd0;
      cfg_n        <= 16'd0;
      cfg_k        <= 16'd0;
      cfg_flags    <= 8'd0;
      cfg_scale    <= 32'd0;
      cfg_zp       <= 32'd0;
    end else if (accept && is_cfg) begin
      if (funct7[0]) begin
        cfg_a_base <= nice_req_rs1;
        cfg_b_base <= nice_req_rs2;
      end
      if (funct7[1]) begin
        cfg_c_base   <= nice_req_rs1;
        cfg_stride_a <= nice_req_rs2;
      end
      if (funct7[2]) begin
        cfg_stride_b <= nice_req_rs1;
        cfg_stride_c <= nice_req_rs2;
      end
      if (funct7[3]) begin
        cfg_m <= nice_req_rs1[15:0];
        cfg_n <= nice_req_rs2[15:0];
      end
      if (funct7[4]) begin
        cfg_k     <= nice_req_rs1[15:0];
        cfg_flags <= nice_req_rs2[7:0];
      end
      if (funct7[5]) begin
        cfg_scale <= nice_req_rs1;
        cfg_zp    <= nice_req_rs2;
      end
    end
  end

endmodule
